// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle processor control path.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned SEL_W    = 2;

  // Instruction opcodes, instr[15:12]
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_SW    = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_JMP   = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 4'b1111;

  // Op codes consumed by the ALU control decoder; 2'b11 is never issued
  localparam logic [ALUOP_W-1:0] ALU_ADD  = 2'b00;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_FUNC = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_REG = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_ONE = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM = 2'b10;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  // Full datapath control word for one state
  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic               pc_write;
    logic               pc_write_cond;
    logic [SEL_W-1:0]   pc_source;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               halted;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Maps an FSM state to its Moore control word; every field defaults to 0.
module ctrl_out_decode
  import cpu_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t cw
);

  // One control word per state, everything else left deasserted
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.ir_write  = 1'b1;
        cw.pc_write  = 1'b1;
        cw.alu_src_b = SRCB_ONE;
        cw.alu_op    = ALU_ADD;
        cw.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REG;
        cw.alu_op    = ALU_FUNC;
      end
      S_WB_R: begin
        cw.reg_dst   = 1'b1;
        cw.reg_write = 1'b1;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        cw.mem_read = 1'b1;
        cw.iord     = 1'b1;
      end
      S_MEM_WB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        cw.mem_write = 1'b1;
        cw.iord      = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_src_b     = SRCB_REG;
        cw.alu_op        = ALU_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDI_WB: begin
        cw.reg_write = 1'b1;
      end
      S_JUMP: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = PCSRC_JUMP;
      end
      S_HALT: begin
        cw.halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned OPW  = OPCODE_W,
  parameter int unsigned RETW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [1:0]      alu_op,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic [1:0]      pc_source,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            halted,
  output logic            illegal,
  output logic [RETW-1:0] retired
);

  state_t     state;
  state_t     state_d;
  ctrl_word_t cw_q;
  ctrl_word_t cw_d;
  logic       retire;
  logic       bad_op;
  logic       unused_zero;

  // zero only qualifies pc_write_cond inside the datapath
  assign unused_zero = zero;

  // Next-state selection and end-of-instruction detection
  always_comb begin
    state_d = state;
    retire  = 1'b0;
    bad_op  = 1'b0;
    case (state)
      // cw_q is cleared by reset, so the first post-reset cycle never accepts data
      S_FETCH:    if (cw_q.mem_read && mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPW'(OP_RTYPE):        state_d = S_EXEC_R;
          OPW'(OP_LW),
          OPW'(OP_SW):           state_d = S_MEM_ADDR;
          OPW'(OP_BEQ):          state_d = S_BRANCH;
          OPW'(OP_ADDI):         state_d = S_ADDI_EX;
          OPW'(OP_JMP):          state_d = S_JUMP;
          OPW'(OP_HALT):         state_d = S_HALT;
          default: begin
            state_d = S_HALT;
            bad_op  = 1'b1;
          end
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_MEM_ADDR: state_d = (opcode == OPW'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_WB_R, S_MEM_WB, S_BRANCH, S_ADDI_WB, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Control word is decoded from the next state so it lines up with the state register
  ctrl_out_decode u_decode (
    .state (state_d),
    .cw    (cw_d)
  );

  // State, registered control word, retire counter and sticky illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      cw_q    <= '0;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_d;
      cw_q  <= cw_d;
      if (retire) retired <= retired + RETW'(1);
      if (bad_op) illegal <= 1'b1;
    end
  end

  // Fetch-time loads fire only in the cycle the instruction word is returned
  assign ir_write      = cw_q.ir_write & mem_ready;
  assign pc_write      = cw_q.pc_write & (mem_ready | ~cw_q.ir_write);

  assign alu_op        = cw_q.alu_op;
  assign alu_src_a     = cw_q.alu_src_a;
  assign alu_src_b     = cw_q.alu_src_b;
  assign pc_write_cond = cw_q.pc_write_cond;
  assign pc_source     = cw_q.pc_source;
  assign iord          = cw_q.iord;
  assign mem_read      = cw_q.mem_read;
  assign mem_write     = cw_q.mem_write;
  assign reg_write     = cw_q.reg_write;
  assign mem_to_reg    = cw_q.mem_to_reg;
  assign reg_dst       = cw_q.reg_dst;
  assign halted        = cw_q.halted;

endmodule
